dl_sdram_writer: RTL and testbench

ROM-download write sequencer sitting between `data_io` (ioctl byte stream, `clk_sd` domain) and the two SDRAM write ports of `sdram`. It edge-detects `ioctl_wr`, buffers each byte with its address in a small FIFO, routes it to port1 (CPU/sound/tile region) or port2 (sprite region, remapped to the 32-bit interleaved layout) and issues one toggle-handshake SDRAM write per byte. It raises `rom_loaded` only after the download has ended and every buffered byte has been acknowledged, replacing the free-running request toggles and the open-loop `rom_loaded` flag.

---
 rtl/dl_sdram_writer_if.sv | 12 +
 rtl/dl_sdram_writer.sv | 212 +++++++++++++++++++++
 tb/tb_dl_sdram_writer.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dl_sdram_writer_if.sv
// One SDRAM write port: toggle request/acknowledge with word address, byte selects and data.
interface dl_sdram_writer_if;
  logic        req;
  logic        ack;
  logic [22:0] a;
  logic [1:0]  ds;
  logic [15:0] d;
  logic        we;

  modport master (output req, a, ds, d, we, input ack);
  modport slave  (input req, a, ds, d, we, output ack);
endinterface

// File: rtl/dl_sdram_writer.sv
// ROM download write sequencer: buffers ioctl bytes in a small FIFO and issues one
// toggle-handshake SDRAM write per byte on port1, or on port2 for the remapped sprite region.
module dl_sdram_writer #(
  parameter logic [24:0] SP_BASE = 25'h10000,
  parameter int          FIFO_AW = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ioctl_downl,
  input  logic                ioctl_wr,
  input  logic [24:0]         ioctl_addr,
  input  logic [7:0]          ioctl_dout,
  dl_sdram_writer_if.master   port1,
  dl_sdram_writer_if.master   port2,
  output logic                busy,
  output logic                overflow,
  output logic                rom_loaded
);

  localparam int                 DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   CNT_MAX = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t               state_q, state_d;
  logic                 sel2_q, sel2_d;
  logic                 wr_q;
  logic                 downl_q;
  logic [FIFO_AW:0]     count_q, count_d;
  logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [32:0]          mem_q [DEPTH];
  logic [32:0]          mem_d [DEPTH];

  logic                 p1_req_q, p1_req_d, p1_we_q, p1_we_d;
  logic [22:0]          p1_a_q, p1_a_d;
  logic [1:0]           p1_ds_q, p1_ds_d;
  logic [15:0]          p1_d_q, p1_d_d;
  logic                 p2_req_q, p2_req_d, p2_we_q, p2_we_d;
  logic [22:0]          p2_a_q, p2_a_d;
  logic [1:0]           p2_ds_q, p2_ds_d;
  logic [15:0]          p2_d_q, p2_d_d;

  logic                 overflow_q, overflow_d;
  logic                 rom_loaded_q, rom_loaded_d;
  logic                 pending_q, pending_d;

  logic                 push, pop, push_ok, fifo_empty, downl_rise, ack_match;
  logic [24:0]          head_addr;
  logic [7:0]           head_data;
  logic                 head_sel2;
  logic [23:0]          s;

  assign push       = ioctl_downl & ioctl_wr & ~wr_q;
  assign fifo_empty = (count_q == '0);
  assign pop        = (state_q == S_IDLE) & ~fifo_empty;
  assign push_ok    = push & ((count_q != CNT_MAX) | pop);
  assign downl_rise = ioctl_downl & ~downl_q;

  assign head_addr  = mem_q[rd_ptr_q][32:8];
  assign head_data  = mem_q[rd_ptr_q][7:0];
  assign head_sel2  = (head_addr >= SP_BASE);
  // Only the low 24 bits of the sprite offset reach the remapped address.
  assign s          = head_addr[23:0] - SP_BASE[23:0];
  assign ack_match  = sel2_q ? (port2.ack == p2_req_q) : (port1.ack == p1_req_q);

  always_comb begin
    state_d      = state_q;
    sel2_d       = sel2_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    mem_d        = mem_q;
    p1_req_d     = p1_req_q;
    p1_we_d      = p1_we_q;
    p1_a_d       = p1_a_q;
    p1_ds_d      = p1_ds_q;
    p1_d_d       = p1_d_q;
    p2_req_d     = p2_req_q;
    p2_we_d      = p2_we_q;
    p2_a_d       = p2_a_q;
    p2_ds_d      = p2_ds_q;
    p2_d_d       = p2_d_q;
    overflow_d   = overflow_q;
    rom_loaded_d = rom_loaded_q;
    pending_d    = pending_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = {ioctl_addr, ioctl_dout};
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push_ok && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!push_ok && pop) begin
      count_d = count_q - CNT_ONE;
    end

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          sel2_d  = head_sel2;
          state_d = S_WAIT;
          if (head_sel2) begin
            p2_a_d   = {s[23:16], s[13:0], s[15]};
            p2_ds_d  = {s[14], ~s[14]};
            p2_d_d   = {head_data, head_data};
            p2_we_d  = 1'b1;
            p2_req_d = ~p2_req_q;
          end else begin
            p1_a_d   = head_addr[23:1];
            p1_ds_d  = {head_addr[0], ~head_addr[0]};
            p1_d_d   = {head_data, head_data};
            p1_we_d  = 1'b1;
            p1_req_d = ~p1_req_q;
          end
        end
      end
      S_WAIT: begin
        if (ack_match) begin
          p1_we_d = 1'b0;
          p2_we_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A drop in the same cycle as a new download start still counts against that download.
    if (downl_rise) begin
      overflow_d   = 1'b0;
      rom_loaded_d = 1'b0;
      pending_d    = 1'b1;
    end else if (pending_q && !ioctl_downl && fifo_empty && state_q == S_IDLE) begin
      rom_loaded_d = 1'b1;
      pending_d    = 1'b0;
    end
    if (push && !push_ok) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      sel2_q       <= 1'b0;
      wr_q         <= 1'b0;
      downl_q      <= 1'b0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      p1_req_q     <= 1'b0;
      p1_we_q      <= 1'b0;
      p1_a_q       <= '0;
      p1_ds_q      <= '0;
      p1_d_q       <= '0;
      p2_req_q     <= 1'b0;
      p2_we_q      <= 1'b0;
      p2_a_q       <= '0;
      p2_ds_q      <= '0;
      p2_d_q       <= '0;
      overflow_q   <= 1'b0;
      rom_loaded_q <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel2_q       <= sel2_d;
      wr_q         <= ioctl_wr;
      downl_q      <= ioctl_downl;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      mem_q        <= mem_d;
      p1_req_q     <= p1_req_d;
      p1_we_q      <= p1_we_d;
      p1_a_q       <= p1_a_d;
      p1_ds_q      <= p1_ds_d;
      p1_d_q       <= p1_d_d;
      p2_req_q     <= p2_req_d;
      p2_we_q      <= p2_we_d;
      p2_a_q       <= p2_a_d;
      p2_ds_q      <= p2_ds_d;
      p2_d_q       <= p2_d_d;
      overflow_q   <= overflow_d;
      rom_loaded_q <= rom_loaded_d;
      pending_q    <= pending_d;
    end
  end

  assign port1.req  = p1_req_q;
  assign port1.we   = p1_we_q;
  assign port1.a    = p1_a_q;
  assign port1.ds   = p1_ds_q;
  assign port1.d    = p1_d_q;
  assign port2.req  = p2_req_q;
  assign port2.we   = p2_we_q;
  assign port2.a    = p2_a_q;
  assign port2.ds   = p2_ds_q;
  assign port2.d    = p2_d_q;

  assign busy       = ~fifo_empty | (state_q == S_WAIT);
  assign overflow   = overflow_q;
  assign rom_loaded = rom_loaded_q;

endmodule

// File: tb/tb_dl_sdram_writer.sv
// Scoreboard bench for dl_sdram_writer: stimulus queues predicted SDRAM writes,
// a monitor pops them whenever a port request toggles.
module tb_dl_sdram_writer;

  localparam logic [24:0] SP_BASE = 25'h10000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_downl = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        busy, overflow, rom_loaded;

  dl_sdram_writer_if p1_if ();
  dl_sdram_writer_if p2_if ();

  dl_sdram_writer #(.SP_BASE(SP_BASE), .FIFO_AW(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ioctl_downl (ioctl_downl),
    .ioctl_wr    (ioctl_wr),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .port1       (p1_if),
    .port2       (p2_if),
    .busy        (busy),
    .overflow    (overflow),
    .rom_loaded  (rom_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          sel2;
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   fail_count = 0;
  int   acks_done = 0;
  int   ack_delay = 3;
  bit   ack_rand = 1'b0;
  int   cnt1, cnt2, dly1, dly2;
  logic prev1, prev2;

  task automatic check_output(string name, logic [63:0] act, logic [63:0] expv);
    tests_run++;
    if (act !== expv) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference mapping from byte address to port, word address and byte lane.
  function automatic exp_t predict(logic [24:0] addr, logic [7:0] data);
    exp_t        e;
    int unsigned ad;
    int unsigned s;
    ad  = 32'(addr);
    e.d = 16'(int'(data) * 257);
    if (ad >= 32'h10000) begin
      s      = ad - 32'h10000;
      e.sel2 = 1'b1;
      e.a    = 23'(((s >> 16) & 255) * 32768 + (s & 16383) * 2 + ((s >> 15) & 1));
      e.ds   = (((s >> 14) & 1) != 0) ? 2'b10 : 2'b01;
    end else begin
      e.sel2 = 1'b0;
      e.a    = 23'(ad / 2);
      e.ds   = ((ad % 2) != 0) ? 2'b10 : 2'b01;
    end
    return e;
  endfunction

  task automatic check_write(bit port);
    exp_t e;
    if (exp_q.size() == 0) begin
      tests_run++;
      fail_count++;
      $display("[TB] FAIL unexpected_write: port%0d req toggled with nothing expected", port ? 2 : 1);
      return;
    end
    e = exp_q.pop_front();
    check_output("write_port_sel2", 64'(port), 64'(e.sel2));
    if (port) begin
      check_output("p2_a", 64'(p2_if.a), 64'(e.a));
      check_output("p2_ds", 64'(p2_if.ds), 64'(e.ds));
      check_output("p2_d", 64'(p2_if.d), 64'(e.d));
      check_output("p2_we_on_issue", 64'(p2_if.we), 64'(1));
      check_output("p1_we_idle", 64'(p1_if.we), 64'(0));
    end else begin
      check_output("p1_a", 64'(p1_if.a), 64'(e.a));
      check_output("p1_ds", 64'(p1_if.ds), 64'(e.ds));
      check_output("p1_d", 64'(p1_if.d), 64'(e.d));
      check_output("p1_we_on_issue", 64'(p1_if.we), 64'(1));
      check_output("p2_we_idle", 64'(p2_if.we), 64'(0));
    end
  endtask

  // SDRAM model side: ack follows req after a programmable delay, cleared by the shared reset.
  initial begin
    p1_if.ack = 1'b0; cnt1 = 0; dly1 = 1;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        p1_if.ack = 1'b0; cnt1 = 0;
      end else if (p1_if.req != p1_if.ack) begin
        if (cnt1 == 0) dly1 = ack_rand ? int'($urandom_range(1, 5)) : ack_delay;
        cnt1++;
        if (cnt1 >= dly1) begin
          p1_if.ack = p1_if.req; cnt1 = 0; acks_done++;
        end
      end
    end
  end

  initial begin
    p2_if.ack = 1'b0; cnt2 = 0; dly2 = 1;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        p2_if.ack = 1'b0; cnt2 = 0;
      end else if (p2_if.req != p2_if.ack) begin
        if (cnt2 == 0) dly2 = ack_rand ? int'($urandom_range(1, 5)) : ack_delay;
        cnt2++;
        if (cnt2 >= dly2) begin
          p2_if.ack = p2_if.req; cnt2 = 0; acks_done++;
        end
      end
    end
  end

  initial begin
    prev1 = 1'b0; prev2 = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev1 = 1'b0; prev2 = 1'b0;
      end else begin
        if (p1_if.req !== prev1) begin prev1 = p1_if.req; check_write(1'b0); end
        if (p2_if.req !== prev2) begin prev2 = p2_if.req; check_write(1'b1); end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_stimulus(logic [24:0] addr, logic [7:0] data, bit expect_write);
    ioctl_addr = addr;
    ioctl_dout = data;
    if (expect_write) exp_q.push_back(predict(addr, data));
    ioctl_wr = 1'b1;
    step();
    ioctl_wr = 1'b0;
    step();
  endtask

  task automatic wait_drained(string name, int limit);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < limit) begin step(); n++; end
    check_output(name, 64'(n < limit), 64'(1));
  endtask

  task automatic wait_rom(string name, int limit);
    int n = 0;
    while (!rom_loaded && n < limit) begin step(); n++; end
    check_output(name, 64'(rom_loaded), 64'(1));
  endtask

  task automatic check_reset_outputs();
    check_output("rst_p1_req", 64'(p1_if.req), 64'(0));
    check_output("rst_p1_we", 64'(p1_if.we), 64'(0));
    check_output("rst_p1_bus", 64'({p1_if.a, p1_if.ds, p1_if.d}), 64'(0));
    check_output("rst_p2_req", 64'(p2_if.req), 64'(0));
    check_output("rst_p2_we", 64'(p2_if.we), 64'(0));
    check_output("rst_p2_bus", 64'({p2_if.a, p2_if.ds, p2_if.d}), 64'(0));
    check_output("rst_busy", 64'(busy), 64'(0));
    check_output("rst_overflow", 64'(overflow), 64'(0));
    check_output("rst_rom_loaded", 64'(rom_loaded), 64'(0));
  endtask

  initial begin
    int   n;
    int   base;
    bit   early;
    logic [24:0] addr;

    reset_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ioctl_downl = 1'($urandom);
      ioctl_wr    = 1'($urandom);
      ioctl_addr  = 25'($urandom);
      ioctl_dout  = 8'($urandom);
      step();
      check_reset_outputs();
    end
    ioctl_downl = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    step();
    reset_n = 1'b1;
    step();

    // Single port1 byte.
    ack_rand = 1'b0; ack_delay = 3;
    ioctl_downl = 1'b1; step();
    apply_stimulus(25'h00003, 8'h5A, 1'b1);
    wait_drained("p1_drain", 50);
    check_output("p1_a_final", 64'(p1_if.a), 64'(23'h000001));
    check_output("p1_ds_final", 64'(p1_if.ds), 64'(2'b10));
    check_output("p1_d_final", 64'(p1_if.d), 64'(16'h5A5A));
    check_output("p1_req_once", 64'(p1_if.req), 64'(1));
    check_output("p1_we_cleared", 64'(p1_if.we), 64'(0));
    check_output("p2_req_untouched", 64'(p2_if.req), 64'(0));
    check_output("p2_we_untouched", 64'(p2_if.we), 64'(0));
    ioctl_downl = 1'b0;
    wait_rom("p1_rom_loaded", 20);

    // Strobes outside a download are ignored.
    apply_stimulus(25'h00010, 8'h77, 1'b0);
    repeat (4) step();
    check_output("ignored_busy", 64'(busy), 64'(0));
    check_output("ignored_rom_loaded", 64'(rom_loaded), 64'(1));

    // Single port2 byte through the sprite remap.
    ioctl_downl = 1'b1; step();
    check_output("rise_clears_rom_loaded", 64'(rom_loaded), 64'(0));
    apply_stimulus(25'h1C001, 8'hC3, 1'b1);
    wait_drained("p2_drain", 50);
    check_output("p2_a_final", 64'(p2_if.a), 64'({8'h00, 14'h0001, 1'b1}));
    check_output("p2_ds_final", 64'(p2_if.ds), 64'(2'b10));
    check_output("p2_d_final", 64'(p2_if.d), 64'(16'hC3C3));
    check_output("p2_req_once", 64'(p2_if.req), 64'(1));
    check_output("p1_req_untouched", 64'(p1_if.req), 64'(1));
    check_output("p1_we_untouched", 64'(p1_if.we), 64'(0));
    ioctl_downl = 1'b0;
    wait_rom("p2_rom_loaded", 20);

    // Burst of six with a slow ack: one outstanding plus four buffered, the sixth dropped.
    ack_delay = 20;
    ioctl_downl = 1'b1; step();
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(25'h00100 + 25'(i), 8'(8'h10 + i), i < 5);
    end
    check_output("overflow_set", 64'(overflow), 64'(1));
    ioctl_downl = 1'b0;
    wait_rom("burst_rom_loaded", 300);
    check_output("overflow_sticky", 64'(overflow), 64'(1));
    check_output("burst_all_written", 64'(exp_q.size()), 64'(0));

    // Download ends with three bytes still buffered.
    ack_delay = 12;
    ioctl_downl = 1'b1; step();
    check_output("overflow_cleared", 64'(overflow), 64'(0));
    check_output("drain_rom_cleared", 64'(rom_loaded), 64'(0));
    base = acks_done;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(SP_BASE + 25'(i * 3), 8'($urandom), 1'b1);
    end
    ioctl_downl = 1'b0;
    check_output("drain_busy", 64'(busy), 64'(1));
    early = 1'b0; n = 0;
    while (acks_done < base + 4 && n < 200) begin
      if (rom_loaded) early = 1'b1;
      step(); n++;
    end
    check_output("drain_acks", 64'(acks_done - base), 64'(4));
    check_output("drain_no_early_rom", 64'(early), 64'(0));
    check_output("drain_rom_at_last_ack", 64'(rom_loaded), 64'(0));
    check_output("drain_busy_at_last_ack", 64'(busy), 64'(1));
    step();
    check_output("drain_busy_fall", 64'(busy), 64'(0));
    check_output("drain_rom_still_low", 64'(rom_loaded), 64'(0));
    step();
    check_output("drain_rom_rise", 64'(rom_loaded), 64'(1));

    // Random addresses, data, gaps and ack latencies without overrunning the FIFO.
    ack_rand = 1'b1;
    ioctl_downl = 1'b1; step();
    for (int i = 0; i < 40; i++) begin
      n = 0;
      while (exp_q.size() > 2 && n < 400) begin step(); n++; end
      check_output("rand_room", 64'(exp_q.size() <= 2), 64'(1));
      repeat ($urandom_range(0, 3)) step();
      if ($urandom_range(0, 1) == 0) addr = 25'($urandom_range(0, 32'h0FFFF));
      else addr = 25'($urandom_range(32'h10000, 32'h1FFFFFF));
      apply_stimulus(addr, 8'($urandom), 1'b1);
    end
    ioctl_downl = 1'b0;
    wait_rom("rand_rom_loaded", 600);
    check_output("rand_all_written", 64'(exp_q.size()), 64'(0));
    check_output("rand_no_overflow", 64'(overflow), 64'(0));

    // Reset while a write is outstanding, then a clean download.
    ack_rand = 1'b0; ack_delay = 30;
    ioctl_downl = 1'b1; step();
    apply_stimulus(25'h00040, 8'hA1, 1'b1);
    apply_stimulus(25'h00041, 8'hB2, 1'b1);
    check_output("midop_in_wait", 64'(busy), 64'(1));
    reset_n = 1'b0;
    ioctl_downl = 1'b0;
    #1;
    check_output("midop_p1_req", 64'(p1_if.req), 64'(0));
    check_output("midop_p1_we", 64'(p1_if.we), 64'(0));
    check_output("midop_busy", 64'(busy), 64'(0));
    check_output("midop_rom_loaded", 64'(rom_loaded), 64'(0));
    step();
    exp_q.delete();
    reset_n = 1'b1;
    step();
    check_output("post_reset_busy", 64'(busy), 64'(0));
    ack_delay = 2;
    ioctl_downl = 1'b1; step();
    apply_stimulus(25'h00200, 8'h3C, 1'b1);
    apply_stimulus(25'h12345, 8'hE7, 1'b1);
    ioctl_downl = 1'b0;
    wait_rom("post_reset_rom_loaded", 100);
    check_output("post_reset_all_written", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
